debug_trace_uart: RTL and testbench

- Consumer end of the CPU debug interface. Samples the core's 32-bit debug data output and buffers captured words in a small FIFO.
- Transmits each captured word as ASCII text over a UART 8N1 line: 8 uppercase hex digits, MSB nibble first, then CR and LF.
- Sits beside the cpu instance so that CPU results are observable on silicon/FPGA without a simulator monitor.

---
 rtl/debug_trace_uart.sv | 150 +++++++++++++++
 tb/tb_debug_trace_uart.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_uart.sv
// Debug trace port: captures CPU debug words into a small FIFO and prints each
// one on a UART 8N1 line as eight uppercase hex digits followed by CR LF.
module debug_trace_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter bit CHANGE_ONLY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_word;
  logic [31:0]   word;
  logic [7:0]    char_q;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    char_idx;
  logic          baud_wrap, fifo_empty, fifo_full, capture, pop, push;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h37 + {4'd0, nib});
  endfunction

  function automatic logic [7:0] char_of(input logic [31:0] w, input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd8:    c = 8'h0D;
      4'd9:    c = 8'h0A;
      default: c = hex_ascii(w[{~idx[2:0], 2'b00} +: 4]);
    endcase
    return c;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign capture    = data_valid && (!CHANGE_ONLY || (data_in != last_word));
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push       = capture && (!fifo_full || pop);
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last_word <= data_in;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (capture && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (baud_wrap) state_next = DATA;
      DATA:    if (baud_wrap && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (baud_wrap) state_next = (char_idx == 4'd9) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered so it changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
    end else begin
      baud_cnt <= ((state == IDLE) || baud_wrap) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            char_idx <= '0;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            bit_idx <= '0;
            tx      <= char_q[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= char_q[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (baud_wrap && (char_idx != 4'd9)) begin
            char_idx <= char_idx + 4'd1;
            tx       <= 1'b0;
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      word   <= fifo_mem[rd_ptr];
      char_q <= hex_ascii(fifo_mem[rd_ptr][31:28]);
    end else if ((state == STOP) && baud_wrap && (char_idx != 4'd9)) begin
      char_q <= char_of(word, char_idx + 4'd1);
    end
  end

endmodule

// File: tb/tb_debug_trace_uart.sv
// Bench for debug_trace_uart: two instances (every strobe / change-only) with
// UART receivers feeding a byte scoreboard plus directed timing checks.
module tb_debug_trace_uart;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d_a, d_b;
  logic        v_a, v_b;
  logic        tx_a, tx_b, busy_a, busy_b, ovf_a, ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_a[$], rx_a[$], exp_b[$], rx_b[$];

  logic [7:0] lit_2a [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h32, 8'h41, 8'h0D, 8'h0A};
  logic [7:0] lit_fe [10] = '{8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h39, 8'h30, 8'h0D, 8'h0A};
  logic [31:0] ow [6] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000,
                          32'hFFFF_FFFF, 32'h0F1E_2D3C, 32'h5A5A_5A5A};
  logic [31:0] tw [6] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
                          32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC};

  always #5 clk = ~clk;

  debug_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CHANGE_ONLY(0)) dut_a (
    .clk(clk), .reset(rst_n), .data_in(d_a), .data_valid(v_a),
    .tx(tx_a), .busy(busy_a), .overflow(ovf_a)
  );

  debug_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CHANGE_ONLY(1)) dut_b (
    .clk(clk), .reset(rst_n), .data_in(d_b), .data_valid(v_b),
    .tx(tx_b), .busy(busy_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic line_of(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction

  function automatic int rx_size(input int which);
    return (which != 0) ? rx_b.size() : rx_a.size();
  endfunction

  // Receiver: samples mid-bit on falling clk edges; {stop_ok & start_ok, byte}.
  task automatic uart_rx(input int which);
    logic [7:0] b;
    logic       ok, bad;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line_of(which) === 1'b0) begin
        ok = 1'b1; bad = 1'b0; b = '0;
        repeat (CPB / 2) @(negedge clk);
        if (rst_n !== 1'b1) bad = 1'b1;
        if (line_of(which) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          if (rst_n !== 1'b1) bad = 1'b1;
          b[i] = line_of(which);
        end
        repeat (CPB) @(negedge clk);
        if (rst_n !== 1'b1) bad = 1'b1;
        if (line_of(which) !== 1'b1) ok = 1'b0;
        if (!bad) begin
          if (which != 0) rx_b.push_back({ok, b});
          else            rx_a.push_back({ok, b});
        end
      end
    end
  endtask

  initial uart_rx(0);
  initial uart_rx(1);

  task automatic push_byte(input int which, input logic [7:0] c);
    if (which != 0) exp_b.push_back({1'b1, c});
    else            exp_a.push_back({1'b1, c});
  endtask

  task automatic push_word(input int which, input logic [31:0] w);
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) begin
      nib = w[31 - 4*i -: 4];
      push_byte(which, (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h41 + {4'd0, nib} - 8'd10));
    end
    push_byte(which, 8'h0D);
    push_byte(which, 8'h0A);
  endtask

  task automatic check_stream(input int which, input string tag, input int budget);
    int t = 0;
    int want;
    logic [8:0] e, g;
    want = (which != 0) ? exp_b.size() : exp_a.size();
    while (rx_size(which) < want && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_complete"}, 32'(t < budget), 32'd1);
    for (int i = 0; i < want; i++) begin
      g = 'x;
      if (which != 0) begin
        e = exp_b.pop_front();
        if (rx_b.size() > 0) g = rx_b.pop_front();
      end else begin
        e = exp_a.pop_front();
        if (rx_a.size() > 0) g = rx_a.pop_front();
      end
      chk($sformatf("%s[%0d]", tag, i), 32'(g), 32'(e));
    end
  endtask

  task automatic strobe_a(input logic [31:0] w);
    @(negedge clk);
    d_a = w; v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad_cycles;
    rst_n = 1'b1; d_a = '0; d_b = '0; v_a = 1'b0; v_b = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_a", 32'(tx_a), 32'd1);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_ovf_a", 32'(ovf_a), 32'd0);
    chk("reset_tx_b", 32'(tx_b), 32'd1);
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    chk("reset_ovf_b", 32'(ovf_b), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Change-only: a first word equal to the cleared last-captured value is ignored
    @(negedge clk);
    d_b = 32'h0; v_b = 1'b1;
    @(posedge clk); #1;
    v_b = 1'b0;
    chk("zero_word_busy_b", 32'(busy_b), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_word_tx_b", 32'(tx_b), 32'd1);

    // Single word 0x2A: latency, frame length and character content
    @(negedge clk);
    d_a = 32'h0000_002A; v_a = 1'b1;
    @(posedge clk); #1;
    v_a = 1'b0;
    chk("t1_tx_on_capture", 32'(tx_a), 32'd1);
    chk("t1_busy_on_capture", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    chk("t1_tx_fall", 32'(tx_a), 32'd0);
    n = 0;
    while (busy_a && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t1_busy_cycles", 32'(n), 32'd400);
    chk("t1_tx_idle", 32'(tx_a), 32'd1);
    for (int i = 0; i < 10; i++) push_byte(0, lit_2a[i]);
    check_stream(0, "t1_char", 100);

    // Hex letters and the 9/0 digit boundary
    strobe_a(32'hFEDC_BA90);
    for (int i = 0; i < 10; i++) push_byte(0, lit_fe[i]);
    check_stream(0, "hex_char", 600);
    repeat (5) @(posedge clk);

    // Three identical strobes: change-only sends one word, the other sends three
    @(negedge clk);
    d_a = 32'h1234_5678; v_a = 1'b1;
    d_b = 32'h1234_5678; v_b = 1'b1;
    repeat (3) @(negedge clk);
    v_a = 1'b0; v_b = 1'b0;
    push_word(0, 32'h1234_5678);
    push_word(0, 32'h1234_5678);
    push_word(0, 32'h1234_5678);
    push_word(1, 32'h1234_5678);
    n = 0;
    while (busy_a && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("co0_activity_in_range", 32'(n >= 1200 && n <= 1203), 32'd1);
    chk("co1_busy_b_done", 32'(busy_b), 32'd0);
    chk("co1_rx_count", 32'(rx_size(1)), 32'd10);
    check_stream(1, "co1_char", 100);
    check_stream(0, "co0_char", 100);

    // Six back-to-back words into a depth-4 FIFO: the sixth is dropped
    @(negedge clk);
    d_a = ow[0]; v_a = 1'b1;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("ovf_before_drop", 32'(ovf_a), 32'd0);
      d_a = ow[k];
    end
    @(negedge clk);
    v_a = 1'b0;
    chk("ovf_after_drop", 32'(ovf_a), 32'd1);
    for (int k = 0; k < 5; k++) push_word(0, ow[k]);
    check_stream(0, "ovf_char", 2500);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    chk("ovf_busy_done", 32'(busy_a), 32'd0);

    // Reset in the middle of char 3's data bits
    strobe_a(32'h0BAD_CAFE);
    repeat (140) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_a), 32'd1);
    chk("midreset_busy", 32'(busy_a), 32'd0);
    chk("midreset_ovf", 32'(ovf_a), 32'd0);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    bad_cycles = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad_cycles++;
    end
    chk("postreset_quiet", 32'(bad_cycles), 32'd0);
    rx_a.delete();
    exp_a.delete();

    // Push on the edge where the FIFO is full and IDLE pops the head
    strobe_a(tw[0]);
    for (int k = 1; k < 5; k++) strobe_a(tw[k]);
    repeat (401 - 8) @(negedge clk);
    chk("edge_push_ovf_before", 32'(ovf_a), 32'd0);
    d_a = tw[5]; v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    chk("edge_push_ovf_after", 32'(ovf_a), 32'd0);
    for (int k = 0; k < 6; k++) push_word(0, tw[k]);
    check_stream(0, "edge_push_char", 3000);
    repeat (5) @(posedge clk);
    #1;
    chk("edge_push_ovf_final", 32'(ovf_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
